matrix2scan: RTL and testbench

MATRIX2SCAN -- requirements
Module: matrix2scan

---
 rtl/matrix2scan_pkg.sv | 18 +
 rtl/mrom2scan.sv | 34 +++
 rtl/matrix2scan.sv | 117 +++++++++++
 tb/tb_matrix2scan.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/matrix2scan_pkg.sv
// Shared keyboard definitions: scanner states, special scancodes, slot geometry.
package matrix2scan_pkg;

  localparam int unsigned SLOTS   = 66;
  localparam int unsigned IDX_W   = 7;
  localparam int unsigned SC_W    = 8;
  localparam int unsigned MATRIX_W = 64;

  localparam logic [SC_W-1:0] SC_F0       = 8'hF0;
  localparam logic [SC_W-1:0] SC_UNMAPPED = 8'hFF;

  typedef enum logic [1:0] {
    SCAN      = 2'd0,
    EMIT_BRK  = 2'd1,
    EMIT_CODE = 2'd2
  } state_t;

endpackage

// File: rtl/mrom2scan.sv
// Slot-to-PS/2 set-2 scancode lookup (combinational).
// Ports: slot  - 7-bit slot index (0..63 matrix row*8+col, 64 SS, 65 US)
//        code_c - scancode, SC_UNMAPPED when the slot has no key assigned
module mrom2scan
  import matrix2scan_pkg::*;
(
  input  logic [IDX_W-1:0] slot,
  output logic [SC_W-1:0]  code_c
);

  // Key identifier as row in [6:4], col in [2:0], bit 3 unused.
  logic [6:0] key;
  assign key = {slot[5:3], 1'b0, slot[2:0]};

  always_comb begin
    code_c = SC_UNMAPPED;
    if (slot == IDX_W'(64)) begin
      code_c = 8'h12;
    end else if (slot == IDX_W'(65)) begin
      code_c = 8'h14;
    end else if (slot < IDX_W'(64)) begin
      case (key)
        7'h02:   code_c = 8'h5A;
        7'h12:   code_c = 8'h76;
        7'h41:   code_c = 8'h1C;
        7'h61:   code_c = 8'h15;
        7'h04:   code_c = 8'h6B;
        7'h20:   code_c = 8'h45;
        default: code_c = SC_UNMAPPED;
      endcase
    end
  end

endmodule

// File: rtl/matrix2scan.sv
// Converts Vector-06C key matrix state changes into PS/2 set-2 make/break bytes.
// Ports: c          - clock
//        reset_n    - synchronous active-low reset
//        matrix     - 64 key states, bit row*8+col, 1 = pressed
//        mod_ss     - SS modifier state
//        mod_us     - US modifier state
//        q_scancode - byte being offered
//        q_valid    - q_scancode is valid
//        q_ready    - consumer accepts byte when valid and ready
//        busy       - scanner is emitting (not in SCAN)
module matrix2scan
  import matrix2scan_pkg::*;
(
  input  logic                c,
  input  logic                reset_n,
  input  logic [MATRIX_W-1:0] matrix,
  input  logic                mod_ss,
  input  logic                mod_us,
  output logic [SC_W-1:0]     q_scancode,
  output logic                q_valid,
  input  logic                q_ready,
  output logic                busy
);

  state_t            state, state_n;
  logic [IDX_W-1:0]  idx, idx_n, idx_inc;
  logic [SLOTS-1:0]  shadow, shadow_n;
  logic [SLOTS-1:0]  live_c;
  logic              lat_bit, lat_bit_n;
  logic [SC_W-1:0]   lat_code, lat_code_n;
  logic [SC_W-1:0]   q_scancode_n;
  logic              q_valid_n;
  logic              busy_n;
  logic [SC_W-1:0]   rom_code_c;

  assign live_c  = {mod_us, mod_ss, matrix};
  assign idx_inc = (idx == IDX_W'(SLOTS - 1)) ? '0 : idx + IDX_W'(1);

  mrom2scan u_rom (
    .slot   (idx),
    .code_c (rom_code_c)
  );

  // Next-state and output logic.
  always_comb begin
    state_n      = state;
    idx_n        = idx;
    shadow_n     = shadow;
    lat_bit_n    = lat_bit;
    lat_code_n   = lat_code;
    q_valid_n    = q_valid;
    q_scancode_n = q_scancode;
    case (state)
      SCAN: begin
        if (live_c[idx] != shadow[idx]) begin
          if (rom_code_c == SC_UNMAPPED) begin
            // No key assigned: absorb the change silently.
            shadow_n[idx] = live_c[idx];
            idx_n         = idx_inc;
          end else begin
            // Hold idx so the shadow write on completion hits the same slot.
            lat_bit_n    = live_c[idx];
            lat_code_n   = rom_code_c;
            q_valid_n    = 1'b1;
            q_scancode_n = live_c[idx] ? rom_code_c : SC_F0;
            state_n      = live_c[idx] ? EMIT_CODE : EMIT_BRK;
          end
        end else begin
          idx_n = idx_inc;
        end
      end
      EMIT_BRK: begin
        if (q_valid && q_ready) begin
          q_scancode_n = lat_code;
          state_n      = EMIT_CODE;
        end
      end
      EMIT_CODE: begin
        if (q_valid && q_ready) begin
          shadow_n[idx] = lat_bit;
          idx_n         = idx_inc;
          q_valid_n     = 1'b0;
          state_n       = SCAN;
        end
      end
      default: begin
        state_n   = SCAN;
        q_valid_n = 1'b0;
      end
    endcase
    busy_n = (state_n != SCAN);
  end

  // State and registered outputs.
  always_ff @(posedge c) begin
    if (!reset_n) begin
      state      <= SCAN;
      idx        <= '0;
      shadow     <= '0;
      lat_bit    <= 1'b0;
      lat_code   <= '0;
      q_valid    <= 1'b0;
      q_scancode <= 8'h00;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      shadow     <= shadow_n;
      lat_bit    <= lat_bit_n;
      lat_code   <= lat_code_n;
      q_valid    <= q_valid_n;
      q_scancode <= q_scancode_n;
      busy       <= busy_n;
    end
  end

endmodule

// File: tb/tb_matrix2scan.sv
// Self-checking bench for matrix2scan: directed scenarios plus randomized key toggles.
module tb_matrix2scan;

  typedef logic [7:0] bq_t[$];

  logic        c = 1'b0;
  logic        reset_n = 1'b0;
  logic [63:0] matrix = '0;
  logic        mod_ss = 1'b0;
  logic        mod_us = 1'b0;
  logic [7:0]  q_scancode;
  logic        q_valid;
  logic        q_ready = 1'b0;
  logic        busy;

  int tests = 0;
  int fails = 0;

  bq_t  got;
  bit   hold_prev = 0;
  logic [7:0] prev_code = '0;
  bit   seen_valid = 0;
  bit   model [66];

  always #5 c = ~c;

  matrix2scan dut (
    .c          (c),
    .reset_n    (reset_n),
    .matrix     (matrix),
    .mod_ss     (mod_ss),
    .mod_us     (mod_us),
    .q_scancode (q_scancode),
    .q_valid    (q_valid),
    .q_ready    (q_ready),
    .busy       (busy)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference key table as (row, col, code) entries.
  function automatic logic [7:0] ref_code(input int slot);
    int rows  [6] = '{0, 1, 4, 6, 0, 2};
    int cols  [6] = '{2, 2, 1, 1, 4, 0};
    int codes [6] = '{'h5A, 'h76, 'h1C, 'h15, 'h6B, 'h45};
    if (slot == 64) return 8'h12;
    if (slot == 65) return 8'h14;
    for (int i = 0; i < 6; i++)
      if (slot / 8 == rows[i] && slot % 8 == cols[i]) return 8'(codes[i]);
    return 8'hFF;
  endfunction

  task automatic set_slot(input int slot, input bit v);
    if (slot < 64) matrix[slot] = v;
    else if (slot == 64) mod_ss = v;
    else mod_us = v;
  endtask

  // One clock: drive ready, sample outputs at negedge, log handshakes, check hold/busy rules.
  task automatic cyc(input bit rdy);
    @(negedge c);
    q_ready = rdy;
    if (hold_prev) begin
      chk("hold_valid", 16'(q_valid), 16'h1);
      chk("hold_code", 16'(q_scancode), 16'(prev_code));
    end
    if (q_valid) begin
      chk("busy_while_valid", 16'(busy), 16'h1);
      seen_valid = 1;
    end
    if (q_valid && rdy) got.push_back(q_scancode);
    hold_prev = q_valid && !rdy;
    prev_code = q_scancode;
  endtask

  task automatic run(input int n, input int mode);
    for (int i = 0; i < n; i++)
      cyc(mode == 2 ? 1'($urandom_range(1, 0)) : 1'(mode));
  endtask

  task automatic expect_bytes(input string tag, input bq_t exp);
    chk({tag, "_count"}, 16'(got.size()), 16'(exp.size()));
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      chk({tag, "_byte"}, 16'(got[i]), 16'(exp[i]));
    got.delete();
  endtask

  task automatic wait_valid(input string tag, input int max);
    int n = 0;
    while (!q_valid && n < max) begin cyc(1'b0); n++; end
    chk({tag, "_wait_valid"}, 16'(q_valid), 16'h1);
  endtask

  task automatic do_reset(input int n);
    @(negedge c);
    reset_n = 1'b0;
    q_ready = 1'b0;
    repeat (n) @(negedge c);
    hold_prev = 0;
    reset_n = 1'b1;
    got.delete();
    for (int i = 0; i < 66; i++) model[i] = 0;
  endtask

  initial begin
    bq_t e;
    int  slot;

    // Reset state.
    do_reset(3);
    chk("rst_valid", 16'(q_valid), 16'h0);
    chk("rst_code", 16'(q_scancode), 16'h00);
    chk("rst_busy", 16'(busy), 16'h0);

    // Single make on row 6 col 1.
    matrix[8'h31] = 1'b1;
    run(150, 1);
    e = '{8'h15};
    expect_bytes("make_31", e);
    chk("idle_busy", 16'(busy), 16'h0);

    // Release: break sequence.
    matrix[8'h31] = 1'b0;
    run(150, 1);
    e = '{8'hF0, 8'h15};
    expect_bytes("break_31", e);

    // Backpressure during a break.
    matrix[8'h31] = 1'b1;
    run(150, 1);
    got.delete();
    matrix[8'h31] = 1'b0;
    wait_valid("bp", 200);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0);
      chk("bp_valid", 16'(q_valid), 16'h1);
      chk("bp_code", 16'(q_scancode), 16'hF0);
    end
    run(150, 1);
    e = '{8'hF0, 8'h15};
    expect_bytes("bp_break", e);

    // Simultaneous changes reported in ascending slot order.
    @(negedge c);
    reset_n = 1'b0;
    matrix = '0;
    matrix[2] = 1'b1;
    matrix[10] = 1'b1;
    mod_ss = 1'b1;
    do_reset(2);
    run(250, 1);
    e = '{8'h5A, 8'h76, 8'h12};
    expect_bytes("multi", e);

    // Unmapped slot: silent, shadow absorbs it.
    @(negedge c);
    matrix = '0;
    mod_ss = 1'b0;
    do_reset(2);
    matrix[0] = 1'b1;
    seen_valid = 0;
    run(132, 1);
    chk("unmapped_no_valid", 16'(seen_valid), 16'h0);
    chk("unmapped_shadow", 16'(dut.shadow[0]), 16'h1);
    matrix[0] = 1'b0;
    run(80, 1);

    // Reset mid-emission, held key re-reported.
    do_reset(2);
    matrix[33] = 1'b1;
    wait_valid("midrst", 200);
    @(negedge c);
    reset_n = 1'b0;
    q_ready = 1'b0;
    @(negedge c);
    chk("midrst_valid", 16'(q_valid), 16'h0);
    chk("midrst_code", 16'(q_scancode), 16'h00);
    chk("midrst_busy", 16'(busy), 16'h0);
    reset_n = 1'b1;
    hold_prev = 0;
    got.delete();
    run(150, 1);
    e = '{8'h1C};
    expect_bytes("midrst_remake", e);

    // Randomized single-key toggles with random backpressure.
    @(negedge c);
    matrix = '0;
    do_reset(2);
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(1, 0) == 1) begin
        int pick = $urandom_range(7, 0);
        int mapped [8] = '{2, 10, 33, 49, 4, 16, 64, 65};
        slot = mapped[pick];
      end else begin
        slot = $urandom_range(65, 0);
      end
      model[slot] = !model[slot];
      set_slot(slot, model[slot]);
      e.delete();
      if (ref_code(slot) != 8'hFF) begin
        if (!model[slot]) e.push_back(8'hF0);
        e.push_back(ref_code(slot));
      end
      run(220, 2);
      expect_bytes("rand", e);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
